// File: rtl/instr_controller.sv
// Multi-cycle instruction sequencer: fetches a 16-bit word from a latency-FETCH_LAT ROM,
// decodes it and drives data-memory / register-file / ALU controls as a Moore FSM.
module instr_controller #(
    parameter int ADDR_W    = 7,
    parameter int FETCH_LAT = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [15:0]       ROM_Data,
    output logic [ADDR_W-1:0] PC_Addr,
    output logic [7:0]        D_Addr,
    output logic              D_Wr,
    output logic              RF_s,
    output logic [3:0]        RF_W_addr,
    output logic [3:0]        RF_Ra_addr,
    output logic [3:0]        RF_Rb_addr,
    output logic              RF_W_en,
    output logic [2:0]        ALU_s0,
    output logic [3:0]        State,
    output logic [15:0]       IR_Out,
    output logic [ADDR_W-1:0] PC_Out
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_WAIT   = 4'd2,
        S_DECODE = 4'd3,
        S_NOOP   = 4'd4,
        S_LOAD_A = 4'd5,
        S_LOAD_B = 4'd6,
        S_STORE  = 4'd7,
        S_ADD    = 4'd8,
        S_SUB    = 4'd9,
        S_HALT   = 4'd10
    } state_t;

    // Last WAIT count value; unused when FETCH_LAT is 1 since WAIT is skipped.
    localparam logic [1:0] WAIT_LAST = 2'(FETCH_LAT - 2);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_pc;
    logic [15:0]       r_ir;
    logic [1:0]        r_wait_cnt;
    logic [3:0]        w_opcode;

    assign w_opcode = ROM_Data[15:12];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= S_INIT;
            r_pc       <= '0;
            r_ir       <= '0;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_WAIT)
                r_wait_cnt <= r_wait_cnt + 2'd1;
            else
                r_wait_cnt <= '0;
            if (r_state == S_DECODE) begin
                r_ir <= ROM_Data;
                r_pc <= r_pc + 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT:   w_next = S_FETCH;
            S_FETCH:  w_next = (FETCH_LAT > 1) ? S_WAIT : S_DECODE;
            S_WAIT:   if (r_wait_cnt == WAIT_LAST) w_next = S_DECODE;
            S_DECODE: begin
                // Next state follows the word arriving now, not the stale IR.
                case (w_opcode)
                    4'd1:    w_next = S_STORE;
                    4'd2:    w_next = S_LOAD_A;
                    4'd3:    w_next = S_ADD;
                    4'd4:    w_next = S_SUB;
                    4'd5:    w_next = S_HALT;
                    default: w_next = S_NOOP;
                endcase
            end
            S_LOAD_A: w_next = S_LOAD_B;
            S_NOOP, S_STORE, S_LOAD_B, S_ADD, S_SUB: w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_INIT;
        endcase
    end

    always_comb begin
        D_Addr     = '0;
        D_Wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_addr  = '0;
        RF_Ra_addr = '0;
        RF_Rb_addr = '0;
        RF_W_en    = 1'b0;
        ALU_s0     = '0;
        case (r_state)
            S_STORE: begin
                D_Addr     = r_ir[7:0];
                RF_Ra_addr = r_ir[11:8];
                D_Wr       = 1'b1;
            end
            S_LOAD_A: D_Addr = r_ir[11:4];
            S_LOAD_B: begin
                D_Addr    = r_ir[11:4];
                RF_s      = 1'b1;
                RF_W_addr = r_ir[3:0];
                RF_W_en   = 1'b1;
            end
            S_ADD, S_SUB: begin
                RF_Ra_addr = r_ir[11:8];
                RF_Rb_addr = r_ir[7:4];
                RF_W_addr  = r_ir[3:0];
                RF_W_en    = 1'b1;
                ALU_s0     = (r_state == S_ADD) ? 3'd1 : 3'd2;
            end
            default: ;
        endcase
    end

    // PC only moves when leaving DECODE, so the ROM address is stable across FETCH/WAIT.
    assign PC_Addr = r_pc;
    assign PC_Out  = r_pc;
    assign IR_Out  = r_ir;
    assign State   = r_state;

endmodule

// File: tb/tb_instr_controller.sv
// Directed bench for instr_controller with a two-stage pipelined ROM model (FETCH_LAT = 2).
module tb_instr_controller;

    localparam int ADDR_W = 7;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic [15:0]       ROM_Data;
    logic [ADDR_W-1:0] PC_Addr;
    logic [7:0]        D_Addr;
    logic              D_Wr;
    logic              RF_s;
    logic [3:0]        RF_W_addr;
    logic [3:0]        RF_Ra_addr;
    logic [3:0]        RF_Rb_addr;
    logic              RF_W_en;
    logic [2:0]        ALU_s0;
    logic [3:0]        State;
    logic [15:0]       IR_Out;
    logic [ADDR_W-1:0] PC_Out;

    logic [15:0] rom [0:127];
    logic [15:0] rom_d0, rom_d1;

    int errors = 0;
    int checks = 0;

    instr_controller #(.ADDR_W(ADDR_W), .FETCH_LAT(2)) dut (
        .Clk(Clk), .Reset(Reset), .ROM_Data(ROM_Data), .PC_Addr(PC_Addr),
        .D_Addr(D_Addr), .D_Wr(D_Wr), .RF_s(RF_s), .RF_W_addr(RF_W_addr),
        .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr), .RF_W_en(RF_W_en),
        .ALU_s0(ALU_s0), .State(State), .IR_Out(IR_Out), .PC_Out(PC_Out)
    );

    always #5 Clk = ~Clk;

    // ROM: data for an address appears two clocks after the address is presented.
    always_ff @(posedge Clk) begin
        rom_d0 <= rom[PC_Addr];
        rom_d1 <= rom_d0;
    end
    assign ROM_Data = rom_d1;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_rom(input logic [15:0] w);
        for (int i = 0; i < 128; i++) rom[i] = w;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick(2);
        Reset = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_dwr"},  32'(D_Wr), 0);
        check({tag, "_wen"},  32'(RF_W_en), 0);
        check({tag, "_dadr"}, 32'(D_Addr), 0);
        check({tag, "_rfs"},  32'(RF_s), 0);
        check({tag, "_alu"},  32'(ALU_s0), 0);
    endtask

    initial begin
        fill_rom(16'h0000);
        rom_d0 = '0;
        rom_d1 = '0;

        // Reset state and NOOP sequence
        tick(3);
        check("rst_state", 32'(State), 0);
        check("rst_pc", 32'(PC_Out), 0);
        check("rst_ir", 32'(IR_Out), 0);
        check_idle_outputs("rst");
        Reset = 1'b0;
        tick(); check("noop_s1", 32'(State), 1);
        check("noop_paddr", 32'(PC_Addr), 0);
        tick(); check("noop_s2", 32'(State), 2);
        tick(); check("noop_s3", 32'(State), 3);
        tick(); check("noop_s4", 32'(State), 4);
        check("noop_pc", 32'(PC_Out), 1);
        check_idle_outputs("noop");
        tick(); check("noop_s1b", 32'(State), 1);

        // LOAD 8'h17 -> R5
        fill_rom(16'h0000); rom[0] = 16'h2175;
        do_reset();
        tick(4);
        check("lda_state", 32'(State), 5);
        check("lda_ir", 32'(IR_Out), 32'h2175);
        check("lda_dadr", 32'(D_Addr), 32'h17);
        check("lda_wen", 32'(RF_W_en), 0);
        check("lda_dwr", 32'(D_Wr), 0);
        tick();
        check("ldb_state", 32'(State), 6);
        check("ldb_dadr", 32'(D_Addr), 32'h17);
        check("ldb_rfs", 32'(RF_s), 1);
        check("ldb_wadr", 32'(RF_W_addr), 5);
        check("ldb_wen", 32'(RF_W_en), 1);
        check("ldb_dwr", 32'(D_Wr), 0);
        tick();
        check("ld_back", 32'(State), 1);
        check("ld_wen0", 32'(RF_W_en), 0);

        // ADD R10+R4 -> R3 then SUB
        fill_rom(16'h0000); rom[0] = 16'h3A43; rom[1] = 16'h4A43;
        do_reset();
        tick(4);
        check("add_state", 32'(State), 8);
        check("add_ra", 32'(RF_Ra_addr), 10);
        check("add_rb", 32'(RF_Rb_addr), 4);
        check("add_w", 32'(RF_W_addr), 3);
        check("add_alu", 32'(ALU_s0), 1);
        check("add_wen", 32'(RF_W_en), 1);
        check("add_rfs", 32'(RF_s), 0);
        check("add_dwr", 32'(D_Wr), 0);
        tick();
        check("add_back", 32'(State), 1);
        check("add_paddr", 32'(PC_Addr), 1);
        tick(3);
        check("sub_state", 32'(State), 9);
        check("sub_ra", 32'(RF_Ra_addr), 10);
        check("sub_rb", 32'(RF_Rb_addr), 4);
        check("sub_w", 32'(RF_W_addr), 3);
        check("sub_alu", 32'(ALU_s0), 2);
        check("sub_wen", 32'(RF_W_en), 1);
        check("sub_pc", 32'(PC_Out), 2);

        // STORE R2 -> 8'hC8 then illegal opcode F
        fill_rom(16'h0000); rom[0] = 16'h12C8; rom[1] = 16'hF000;
        do_reset();
        tick(4);
        check("st_state", 32'(State), 7);
        check("st_dwr", 32'(D_Wr), 1);
        check("st_dadr", 32'(D_Addr), 32'hC8);
        check("st_ra", 32'(RF_Ra_addr), 2);
        check("st_wen", 32'(RF_W_en), 0);
        tick();
        check("st_back", 32'(State), 1);
        check("st_dwr0", 32'(D_Wr), 0);
        tick(3);
        check("opF_state", 32'(State), 4);
        check("opF_ir", 32'(IR_Out), 32'hF000);
        check_idle_outputs("opF");

        // PC wrap after 128 NOOPs
        fill_rom(16'h0000);
        do_reset();
        tick(1 + 4 * 127);
        check("wrap_s", 32'(State), 1);
        check("wrap_p127", 32'(PC_Addr), 127);
        tick(3);
        check("wrap_noop", 32'(State), 4);
        check("wrap_pc0", 32'(PC_Out), 0);
        tick();
        check("wrap_fetch", 32'(State), 1);
        check("wrap_paddr", 32'(PC_Addr), 0);

        // HALT held, then Reset
        fill_rom(16'h0000); rom[0] = 16'h5000;
        do_reset();
        tick(4);
        check("halt_state", 32'(State), 10);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("halt_hold", 32'(State), 10);
            check("halt_en", 32'({D_Wr, RF_W_en}), 0);
        end
        Reset = 1'b1;
        tick();
        check("halt_rst_s", 32'(State), 0);
        check("halt_rst_pc", 32'(PC_Out), 0);
        check("halt_rst_ir", 32'(IR_Out), 0);
        Reset = 1'b0;
        tick();
        check("halt_refetch", 32'(State), 1);

        // Reset during LOAD_A
        fill_rom(16'h0000); rom[0] = 16'h2175;
        do_reset();
        tick(4);
        check("rla_pre", 32'(State), 5);
        Reset = 1'b1;
        tick();
        check("rla_state", 32'(State), 0);
        check("rla_pc", 32'(PC_Out), 0);
        check("rla_ir", 32'(IR_Out), 0);
        check_idle_outputs("rla");
        tick();
        check("rla_wen2", 32'(RF_W_en), 0);
        check("rla_state2", 32'(State), 0);
        Reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_controller.md
INSTR_CONTROLLER -- requirements
Module: instr_controller

Interface
REQ-001 Parameter ADDR_W, default 7: instruction ROM address width (128 words).
REQ-002 Parameter FETCH_LAT, default 2, legal 1..4: clocks from PC_Addr stable to ROM_Data valid.
REQ-003 Clk  in  1  rising-edge clock.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 ROM_Data  in  16  instruction word from instruction ROM.
REQ-006 PC_Addr  out  ADDR_W  instruction ROM address (current PC).
REQ-007 D_Addr  out  8  data memory address.
REQ-008 D_Wr  out  1  data memory write enable.
REQ-009 RF_s  out  1  register-file write mux: 1 = data memory, 0 = ALU.
REQ-010 RF_W_addr / RF_Ra_addr / RF_Rb_addr  out  4 each  register-file write / read-A / read-B addresses.
REQ-011 RF_W_en  out  1  register-file write enable.
REQ-012 ALU_s0  out  3  ALU select: 0 pass-A, 1 add, 2 sub.
REQ-013 State  out  4  current FSM state code (debug).
REQ-014 IR_Out / PC_Out  out  16 / ADDR_W  instruction register and PC (debug).

Function
REQ-015 States and codes: INIT 0, FETCH 1, WAIT 2, DECODE 3, NOOP 4, LOAD_A 5, LOAD_B 6, STORE 7, ADD 8, SUB 9, HALT 10.
REQ-016 INIT -> FETCH unconditionally next clock.
REQ-017 FETCH: PC_Addr = PC; -> WAIT if FETCH_LAT > 1, else -> DECODE.
REQ-018 WAIT: hold PC_Addr; counter counts FETCH_LAT-1 cycles total in WAIT, then -> DECODE.
REQ-019 DECODE: IR <= ROM_Data on the clock leaving DECODE; PC <= PC+1, wrapping 2^ADDR_W-1 -> 0.
REQ-020 Opcode IR[15:12]: 0 NOOP, 1 STORE, 2 LOAD, 3 ADD, 4 SUB, 5 HALT; 6..15 -> NOOP.
REQ-021 Transition out of DECODE uses opcode of ROM_Data (same cycle) to select next state.
REQ-022 NOOP -> FETCH; all control outputs 0.
REQ-023 STORE: D_Addr = IR[7:0], RF_Ra_addr = IR[11:8], D_Wr = 1, one cycle; -> FETCH.
REQ-024 LOAD_A: D_Addr = IR[11:4], D_Wr = 0; -> LOAD_B.
REQ-025 LOAD_B: D_Addr = IR[11:4], RF_s = 1, RF_W_addr = IR[3:0], RF_W_en = 1; -> FETCH.
REQ-026 ADD/SUB: RF_Ra_addr = IR[11:8], RF_Rb_addr = IR[7:4], RF_W_addr = IR[3:0], RF_W_en = 1, RF_s = 0, ALU_s0 = 1 (ADD) / 2 (SUB); -> FETCH.
REQ-027 HALT: all enables 0, stays in HALT until Reset; PC not advanced.
REQ-028 Outputs not explicitly driven in a state are 0; D_Wr and RF_W_en never asserted together.
REQ-029 Outputs are a function of registered state and IR only (Moore); no combinational path ROM_Data -> outputs.

Reset
REQ-030 Reset high at a rising edge: state INIT, PC 0, IR 0, WAIT counter 0, all outputs 0, regardless of current state (including mid-LOAD or HALT).
REQ-031 Reset dominates every transition; first FETCH occurs one clock after Reset deasserts.

Verification
REQ-032 Reset then ROM[0]=16'h0000 (NOOP), FETCH_LAT=2 -> states 0,1,2,3,4,1; PC_Out 1 after DECODE.
REQ-033 ROM[0]=16'h2175 (LOAD 8'h17 -> R5) -> LOAD_A D_Addr=8'h17, RF_W_en=0; LOAD_B RF_s=1, RF_W_addr=5, RF_W_en=1.
REQ-034 ROM[0]=16'h3A43 (ADD R10+R4 -> R3) -> ADD state: Ra=10, Rb=4, W=3, ALU_s0=1, RF_W_en=1; ROM word 16'h4A43 -> same with ALU_s0=2.
REQ-035 ROM[0]=16'h12C8 (STORE R2 -> 8'hC8) -> D_Wr=1 one cycle, D_Addr=8'hC8, RF_W_en=0; ROM word 16'hF000 -> NOOP.
REQ-036 ROM all NOOP, run 128 instructions -> PC wraps 127 -> 0 and PC_Addr=0 on next FETCH; ROM[0]=16'h5000 -> HALT held 20 clocks, then Reset -> INIT, PC 0.
REQ-037 Reset asserted during LOAD_A -> next clock State=0, all outputs 0, no RF_W_en pulse.
